multichannel_sample_fifo: RTL and testbench

//  Parametrised successor to the stereo L/R sample FIFO in the splitstreamer path.

---
 rtl/multichannel_sample_fifo_pkg.sv | 25 ++
 rtl/multichannel_sample_fifo_ram.sv | 41 ++++
 rtl/multichannel_sample_fifo.sv | 104 ++++++++++
 tb/tb_multichannel_sample_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multichannel_sample_fifo_pkg.sv
// Shared widths and helpers for the multichannel sample FIFO.
// Pointer and level widths are derived from DEPTH so every module agrees on them.
`ifndef MULTICHANNEL_SAMPLE_FIFO_CH
`define MULTICHANNEL_SAMPLE_FIFO_CH
`define CH(i) (i)*WORDSIZE +: WORDSIZE
`endif

package multichannel_sample_fifo_pkg;

  typedef enum logic [1:0] {
    LVL_HOLD,
    LVL_INC,
    LVL_DEC
  } level_op_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra code point is needed so a completely full FIFO is distinguishable.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/multichannel_sample_fifo_ram.sv
// Frame storage: one write port, one read port.
// REG_READ=1 gives a clearable registered read; REG_READ=0 gives an asynchronous read.
module sample_dp_ram #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int REG_READ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      rdata <= '0;
        else if (clr) rdata <= '0;
        else if (re)  rdata <= mem[raddr];
      end
    end else begin : g_async_read
      assign rdata = mem[raddr];
      // Read strobe and output clears have no meaning for a fall-through read.
      logic unused_ctrl;
      assign unused_ctrl = ^{rst, clr, re};
    end
  endgenerate

endmodule

// File: rtl/multichannel_sample_fifo.sv
// Multichannel audio frame FIFO between I2S capture and the SPDIF encoder.
// Pointers, level counter, watermark flags and sticky error flags live here.
module multichannel_sample_fifo
  import multichannel_sample_fifo_pkg::*;
#(
  parameter int WORDSIZE  = 32,
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             write_en,
  input  logic [CHANNELS*WORDSIZE-1:0]     data_in,
  input  logic                             read_en,
  output logic [CHANNELS*WORDSIZE-1:0]     data_out,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic [level_width(DEPTH)-1:0]    level,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int FRAME_W = CHANNELS * WORDSIZE;
  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int LVL_W   = level_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  level_op_e        level_op;

  // Flush wins over both ports; a write into a full FIFO needs a same-cycle pop.
  assign rd_acc = read_en & ~empty & ~flush;
  assign wr_acc = write_en & (~full | rd_acc) & ~flush;

  always_comb begin
    level_op = LVL_HOLD;
    if (wr_acc && !rd_acc)      level_op = LVL_INC;
    else if (rd_acc && !wr_acc) level_op = LVL_DEC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case (level_op)
        LVL_INC: level <= level + LVL_W'(1);
        LVL_DEC: level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && !wr_acc) overflow  <= 1'b1;
      if (read_en && empty)    underflow <= 1'b1;
    end
  end

  assign full         = (level == LVL_W'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LVL_W'(AF_THRESH));
  assign almost_empty = (level <= LVL_W'(AE_THRESH));

  sample_dp_ram #(
    .WIDTH    (FRAME_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (PTR_W),
    .REG_READ ((FWFT == 0) ? 1 : 0)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_multichannel_sample_fifo.sv
// Bench for multichannel_sample_fifo: table vectors, directed corner sequences and
// randomized traffic checked against a queue-based frame model.
module tb_multichannel_sample_fifo;

  localparam int DEPTH = 16;
  localparam int FW    = 64;

  logic          clk;
  logic          rst;
  logic          flush, write_en, read_en;
  logic [FW-1:0] data_in, data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    level;

  logic          f_flush, f_write_en, f_read_en;
  logic [FW-1:0] f_data_in, f_data_out;
  logic          f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0]    f_level;

  int vectors;
  int miscompares;

  logic [FW-1:0] mq[$];
  bit            m_ovf, m_udf;
  logic [FW-1:0] m_dout;

  typedef struct {
    bit            fl;
    bit            we;
    logic [FW-1:0] din;
    bit            re;
    int            lvl;
    bit            emp;
    bit            udf;
    logic [FW-1:0] dout;
  } vec_t;

  vec_t tbl [8];

  multichannel_sample_fifo #(
    .WORDSIZE(32), .CHANNELS(2), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(12), .AE_THRESH(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  multichannel_sample_fifo #(
    .WORDSIZE(32), .CHANNELS(2), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(12), .AE_THRESH(4)
  ) dut_fwft (
    .clk(clk), .rst(rst), .flush(f_flush), .write_en(f_write_en), .data_in(f_data_in),
    .read_en(f_read_en), .data_out(f_data_out), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .level(f_level),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] frame(input int i);
    return {32'(32'h2000 + i), 32'(32'h1000 + i)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  // Frame-level behaviour: a queue of stored frames plus sticky flags.
  task automatic model_apply(input bit fl, input bit w, input logic [FW-1:0] d, input bit r);
    bit rd_ok, wr_ok;
    if (fl) begin
      model_reset();
    end else begin
      rd_ok = r && (mq.size() > 0);
      wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
      if (r && mq.size() == 0) m_udf = 1'b1;
      if (w && !wr_ok)         m_ovf = 1'b1;
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(d);
    end
  endtask

  task automatic check_model();
    chk("level", FW'(level), FW'(mq.size()));
    chk("empty", FW'(empty), FW'(mq.size() == 0));
    chk("full", FW'(full), FW'(mq.size() == DEPTH));
    chk("almost_full", FW'(almost_full), FW'(mq.size() >= 12));
    chk("almost_empty", FW'(almost_empty), FW'(mq.size() <= 4));
    chk("overflow", FW'(overflow), FW'(m_ovf));
    chk("underflow", FW'(underflow), FW'(m_udf));
    chk("data_out", data_out, m_dout);
  endtask

  task automatic step(input bit fl, input bit w, input logic [FW-1:0] d, input bit r);
    flush    = fl;
    write_en = w;
    data_in  = d;
    read_en  = r;
    @(posedge clk);
    model_apply(fl, w, d, r);
    #1;
    flush    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    check_model();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    flush = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
    f_flush = 1'b0; f_write_en = 1'b0; f_read_en = 1'b0; f_data_in = '0;
    model_reset();

    //               fl we din                    re lvl emp udf dout
    tbl[0] = '{1'b0, 1'b1, 64'h0000_200A_0000_100A, 1'b1, 1, 1'b0, 1'b1, 64'h0};
    tbl[1] = '{1'b0, 1'b0, 64'h0,                   1'b1, 0, 1'b1, 1'b1, 64'h0000_200A_0000_100A};
    tbl[2] = '{1'b0, 1'b1, 64'h0000_200B_0000_100B, 1'b0, 1, 1'b0, 1'b1, 64'h0000_200A_0000_100A};
    tbl[3] = '{1'b0, 1'b1, 64'h0000_200C_0000_100C, 1'b0, 2, 1'b0, 1'b1, 64'h0000_200A_0000_100A};
    tbl[4] = '{1'b0, 1'b0, 64'h0,                   1'b1, 1, 1'b0, 1'b1, 64'h0000_200B_0000_100B};
    tbl[5] = '{1'b1, 1'b1, 64'h0000_200D_0000_100D, 1'b1, 0, 1'b1, 1'b0, 64'h0};
    tbl[6] = '{1'b0, 1'b0, 64'h0,                   1'b1, 0, 1'b1, 1'b1, 64'h0};
    tbl[7] = '{1'b1, 1'b0, 64'h0,                   1'b0, 0, 1'b1, 1'b0, 64'h0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_empty", FW'(empty), FW'(1'b1));
    chk("reset_almost_empty", FW'(almost_empty), FW'(1'b1));
    chk("reset_full", FW'(full), FW'(1'b0));
    check_model();

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].fl, tbl[i].we, tbl[i].din, tbl[i].re);
      chk($sformatf("tbl%0d_level", i), FW'(level), FW'(tbl[i].lvl));
      chk($sformatf("tbl%0d_empty", i), FW'(empty), FW'(tbl[i].emp));
      chk($sformatf("tbl%0d_underflow", i), FW'(underflow), FW'(tbl[i].udf));
      chk($sformatf("tbl%0d_data_out", i), data_out, tbl[i].dout);
    end

    // Fill, overflow on the 17th write, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, frame(i), 1'b0);
    chk("fill_level", FW'(level), FW'(16));
    chk("fill_full", FW'(full), FW'(1'b1));
    step(1'b0, 1'b1, frame(99), 1'b0);
    chk("fill_overflow", FW'(overflow), FW'(1'b1));
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      chk("drain_ch0", FW'(data_out[31:0]), FW'(32'h1000 + i));
    end
    chk("drain_empty", FW'(empty), FW'(1'b1));
    step(1'b0, 1'b0, '0, 1'b1);
    chk("drain_underflow", FW'(underflow), FW'(1'b1));

    // Full with simultaneous read and write.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, frame(i), 1'b0);
    step(1'b0, 1'b1, 64'h5555_5555_AAAA_AAAA, 1'b1);
    chk("fullrw_level", FW'(level), FW'(16));
    chk("fullrw_overflow", FW'(overflow), FW'(1'b0));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("fullrw_last", data_out, 64'h5555_5555_AAAA_AAAA);

    // Flush at level 9 with overflow set and a same-cycle write.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, frame(i + 32), 1'b0);
    step(1'b0, 1'b1, frame(77), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("preflush_level", FW'(level), FW'(9));
    step(1'b1, 1'b1, frame(88), 1'b0);
    chk("flush_level", FW'(level), FW'(0));
    chk("flush_overflow", FW'(overflow), FW'(1'b0));
    chk("flush_empty", FW'(empty), FW'(1'b1));
    step(1'b0, 1'b0, '0, 1'b1);

    // Asynchronous reset with level 7 and underflow set, checked between edges.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, frame(i + 64), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("preRst_level", FW'(level), FW'(7));
    rst = 1'b1;
    #2;
    model_reset();
    chk("arst_level", FW'(level), FW'(0));
    chk("arst_empty", FW'(empty), FW'(1'b1));
    chk("arst_underflow", FW'(underflow), FW'(1'b0));
    chk("arst_data_out", data_out, 64'h0);
    check_model();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First-word-fall-through instance.
    chk("fwft_reset_empty", FW'(f_empty), FW'(1'b1));
    f_write_en = 1'b1;
    f_data_in  = 64'h0000_0000_0000_ABCD;
    @(posedge clk);
    #1;
    f_write_en = 1'b0;
    chk("fwft_empty", FW'(f_empty), FW'(1'b0));
    chk("fwft_data_out", f_data_out, 64'h0000_0000_0000_ABCD);
    chk("fwft_level", FW'(f_level), FW'(1));
    f_read_en = 1'b1;
    @(posedge clk);
    #1;
    f_read_en = 1'b0;
    chk("fwft_pop_empty", FW'(f_empty), FW'(1'b1));
    chk("fwft_pop_level", FW'(f_level), FW'(0));

    // Pointer wrap at a steady level of 3.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, frame(i + 200), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
    chk("wrap_level", FW'(level), FW'(3));

    // Randomized traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 99) < wp,
           {$urandom, $urandom},
           $urandom_range(0, 99) < (100 - wp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
